// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and record index map for the performance counter block
package perf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } run_state_e;

   typedef enum logic {
      DS_IDLE,
      DS_SEND
   } dump_state_e;

   localparam int REC_WIN = 0;
   localparam int REC_CYC = 1;
   localparam int REC_INS = 2;
   localparam int REC_EV0 = 3;

endpackage

// File: rtl/perf_dump.sv
// rtl/perf_dump.sv - shadow register bank and record serializer
// A snapshot is only latched while idle; records then stream out one per handshake.
module perf_dump
   import perf_pkg::*;
#(
   parameter int CW  = 32,
   parameter int NEV = 4,
   parameter int IW  = $clog2(NEV + 3)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    snap_req,
   output logic                    snap_ack,
   input  logic [CW-1:0]           snap_win,
   input  logic [CW-1:0]           snap_cyc,
   input  logic [CW-1:0]           snap_ins,
   input  logic [NEV-1:0][CW-1:0]  snap_ev,
   output logic                    rec_valid,
   input  logic                    rec_ready,
   output logic [IW-1:0]           rec_idx,
   output logic [CW-1:0]           rec_data
);

   localparam int NREC = NEV + 3;
   localparam logic [IW-1:0] LAST_IDX = IW'(NREC - 1);

   dump_state_e              state_q, state_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [NREC-1:0][CW-1:0]  shadow_q, shadow_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      case (state_q)
         DS_IDLE: begin
            if (snap_req) begin
               shadow_d[REC_WIN] = snap_win;
               shadow_d[REC_CYC] = snap_cyc;
               shadow_d[REC_INS] = snap_ins;
               for (int i = 0; i < NEV; i++) begin
                  shadow_d[REC_EV0 + i] = snap_ev[i];
               end
               idx_d   = '0;
               state_d = DS_SEND;
            end
         end
         DS_SEND: begin
            if (rec_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = DS_IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= DS_IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
      end
   end

   // Valid comes straight from the state flop so reset kills the stream at once.
   assign snap_ack  = (state_q == DS_IDLE);
   assign rec_valid = (state_q == DS_SEND);
   assign rec_idx   = idx_q;
   assign rec_data  = shadow_q[idx_q];

endmodule

// File: rtl/perf_ctrl.sv
// rtl/perf_ctrl.sv - run FSM, live saturating counters, window timer and sticky flags
// Snapshots go to perf_dump, which streams them as (index, value) records.
module perf_ctrl
   import perf_pkg::*;
#(
   parameter int CW         = 32,
   parameter int NEV        = 4,
   parameter int WINDOW     = 1024,
   parameter int MAX_CYCLES = 100000,
   parameter int IW         = $clog2(NEV + 3)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            is_halt,
   input  logic            W_v,
   input  logic [NEV-1:0]  ev,
   output logic            rec_valid,
   input  logic            rec_ready,
   output logic [IW-1:0]   rec_idx,
   output logic [CW-1:0]   rec_data,
   output logic [CW-1:0]   cycle,
   output logic            busy,
   output logic            done,
   output logic            timeout,
   output logic            overrun
);

   localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

   run_state_e              state_q, state_d;
   logic [CW-1:0]           cycle_q, cycle_d, instr_q, instr_d, win_id_q, win_id_d;
   logic [NEV-1:0][CW-1:0]  ev_q, ev_d;
   logic [WW-1:0]           win_q, win_d;
   logic                    timeout_q, timeout_d, overrun_q, overrun_d;
   logic                    final_sent_q, final_sent_d;
   logic                    snap_req, snap_ack, wrap, max_hit, last_hs;

   always_comb begin
      state_d      = state_q;
      cycle_d      = cycle_q;
      instr_d      = instr_q;
      ev_d         = ev_q;
      win_d        = win_q;
      win_id_d     = win_id_q;
      timeout_d    = timeout_q;
      overrun_d    = overrun_q;
      final_sent_d = final_sent_q;
      snap_req     = 1'b0;
      wrap         = (win_q == WIN_LAST);
      max_hit      = (cycle_q == CW'(MAX_CYCLES - 1));
      last_hs      = rec_valid & rec_ready & (rec_idx == IW'(NEV + 2));
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_RUN;
               cycle_d      = '0;
               instr_d      = '0;
               ev_d         = '0;
               win_d        = '0;
               win_id_d     = '0;
               timeout_d    = 1'b0;
               overrun_d    = 1'b0;
               final_sent_d = 1'b0;
            end
         end
         ST_RUN: begin
            cycle_d = (&cycle_q) ? cycle_q : cycle_q + CW'(1);
            instr_d = (&instr_q) ? instr_q : instr_q + CW'(W_v);
            for (int i = 0; i < NEV; i++) begin
               ev_d[i] = (&ev_q[i]) ? ev_q[i] : ev_q[i] + CW'(ev[i]);
            end
            win_d = wrap ? '0 : win_q + WW'(1);
            if (is_halt | max_hit) begin
               // A wrap on the stopping edge becomes the final snapshot, never a drop.
               state_d      = ST_FLUSH;
               timeout_d    = timeout_q | max_hit;
               snap_req     = wrap & snap_ack;
               final_sent_d = wrap & snap_ack;
            end else if (wrap) begin
               snap_req  = snap_ack;
               overrun_d = overrun_q | ~snap_ack;
               win_id_d  = win_id_q + CW'(1);
            end
         end
         ST_FLUSH: begin
            if (!final_sent_q) begin
               snap_req     = snap_ack;
               final_sent_d = snap_ack;
            end else if (last_hs) begin
               state_d = ST_DONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cycle_q      <= '0;
         instr_q      <= '0;
         ev_q         <= '0;
         win_q        <= '0;
         win_id_q     <= '0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
         final_sent_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cycle_q      <= cycle_d;
         instr_q      <= instr_d;
         ev_q         <= ev_d;
         win_q        <= win_d;
         win_id_q     <= win_id_d;
         timeout_q    <= timeout_d;
         overrun_q    <= overrun_d;
         final_sent_q <= final_sent_d;
      end
   end

   perf_dump #(
      .CW  (CW),
      .NEV (NEV),
      .IW  (IW)
   ) u_dump (
      .clk       (clk),
      .rst_n     (rst_n),
      .snap_req  (snap_req),
      .snap_ack  (snap_ack),
      .snap_win  (win_id_q),
      .snap_cyc  (cycle_d),
      .snap_ins  (instr_d),
      .snap_ev   (ev_d),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_idx   (rec_idx),
      .rec_data  (rec_data)
   );

   assign cycle   = cycle_q;
   assign busy    = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign done    = (state_q == ST_DONE);
   assign timeout = timeout_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_perf_ctrl.sv
// tb/tb_perf_ctrl.sv - directed self-checking bench for perf_ctrl
module tb_perf_ctrl;

   localparam int CW         = 32;
   localparam int NEV        = 2;
   localparam int WINDOW     = 16;
   localparam int MAX_CYCLES = 50;
   localparam int IW         = $clog2(NEV + 3);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            is_halt = 1'b0;
   logic            W_v = 1'b0;
   logic [NEV-1:0]  ev = '0;
   logic            rec_ready = 1'b0;
   logic            rec_valid, busy, done, timeout, overrun;
   logic [IW-1:0]   rec_idx;
   logic [CW-1:0]   rec_data, cycle;

   int n_chk = 0;
   int n_err = 0;
   bit wv_alt = 1'b0;
   logic [CW-1:0] exp_rec [5];

   always #5 clk = ~clk;

   perf_ctrl #(
      .CW         (CW),
      .NEV        (NEV),
      .WINDOW     (WINDOW),
      .MAX_CYCLES (MAX_CYCLES),
      .IW         (IW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_halt   (is_halt),
      .W_v       (W_v),
      .ev        (ev),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_idx   (rec_idx),
      .rec_data  (rec_data),
      .cycle     (cycle),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout),
      .overrun   (overrun)
   );

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rec(input string tag, input int idx, input logic [CW-1:0] data);
      chk({tag, "_valid"}, CW'(rec_valid), CW'(1));
      chk({tag, "_idx"}, CW'(rec_idx), CW'(idx));
      chk({tag, "_data"}, rec_data, data);
   endtask

   task automatic cyc();
      @(negedge clk);
      if (wv_alt) W_v = ~W_v;
   endtask

   task automatic cycn(input int n);
      repeat (n) cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", CW'(rec_valid), CW'(0));
      chk("rst_busy", CW'(busy), CW'(0));
      chk("rst_done", CW'(done), CW'(0));
      chk("rst_cycle", cycle, CW'(0));
      chk("rst_timeout", CW'(timeout), CW'(0));
      chk("rst_overrun", CW'(overrun), CW'(0));
      chk("rst_data", rec_data, CW'(0));
      rst_n = 1'b1;
      cyc();
      chk("idle_busy", CW'(busy), CW'(0));

      // run 1: periodic bursts, back-pressure hold, then MAX_CYCLES timeout
      ev = 2'b01; W_v = 1'b0; wv_alt = 1'b1; rec_ready = 1'b1; start = 1'b1;
      cyc(); start = 1'b0;
      chk("r1_busy", CW'(busy), CW'(1));
      chk("r1_cycle0", cycle, CW'(0));
      cycn(16);
      exp_rec = '{32'd0, 32'd16, 32'd8, 32'd16, 32'd0};
      for (int i = 0; i < 5; i++) begin
         chk_rec("t1_burst", i, exp_rec[i]);
         cyc();
      end
      chk("t1_gap_valid", CW'(rec_valid), CW'(0));
      chk("t1_live_cycle", cycle, CW'(21));
      cycn(11);
      chk_rec("t2_r0", 0, CW'(1));
      cyc();
      chk_rec("t2_r1", 1, CW'(32));
      cyc();
      chk_rec("t2_r2", 2, CW'(16));
      rec_ready = 1'b0;
      repeat (10) begin
         cyc();
         chk_rec("t2_hold", 2, CW'(16));
      end
      rec_ready = 1'b1;
      cyc();
      chk_rec("t2_r3", 3, CW'(32));
      cyc();
      chk_rec("t2_r4", 4, CW'(0));
      cyc();
      chk("t2_end_valid", CW'(rec_valid), CW'(0));
      cyc();
      chk_rec("t5_w2_r0", 0, CW'(2));
      cyc();
      chk_rec("t5_w2_r1", 1, CW'(48));
      cyc();
      chk("t5_timeout", CW'(timeout), CW'(1));
      chk("t5_cycle", cycle, CW'(50));
      chk("t5_busy", CW'(busy), CW'(1));
      chk("t5_done_early", CW'(done), CW'(0));
      cycn(3);
      chk("t5_gap_valid", CW'(rec_valid), CW'(0));
      cyc();
      exp_rec = '{32'd3, 32'd50, 32'd25, 32'd50, 32'd0};
      for (int i = 0; i < 5; i++) begin
         chk_rec("t5_final", i, exp_rec[i]);
         cyc();
      end
      chk("t5_done", CW'(done), CW'(1));
      chk("t5_busy_off", CW'(busy), CW'(0));
      chk("t5_valid_off", CW'(rec_valid), CW'(0));

      // run 2: sink stalled across two windows -> drop and overrun
      W_v = 1'b1; wv_alt = 1'b0; ev = 2'b10; rec_ready = 1'b0; start = 1'b1;
      cyc(); start = 1'b0;
      chk("r2_timeout_clr", CW'(timeout), CW'(0));
      chk("r2_cycle_clr", cycle, CW'(0));
      chk("r2_done_clr", CW'(done), CW'(0));
      cycn(16);
      chk_rec("t3_first", 0, CW'(0));
      chk("t3_no_overrun", CW'(overrun), CW'(0));
      cycn(16);
      chk("t3_overrun", CW'(overrun), CW'(1));
      chk_rec("t3_held", 0, CW'(0));
      rec_ready = 1'b1;
      cyc();
      chk_rec("t3_cyc", 1, CW'(16));
      cycn(3);
      chk_rec("t3_ev1", 4, CW'(16));
      cycn(12);
      chk_rec("t3_next_win", 0, CW'(2));
      for (int k = 0; k < 40 && !done; k++) cyc();
      chk("t3_done", CW'(done), CW'(1));
      chk("t3_overrun_sticky", CW'(overrun), CW'(1));

      // run 3: halt at cycle 37 with a burst in flight; start in RUN ignored
      W_v = 1'b1; ev = 2'b11; rec_ready = 1'b1; start = 1'b1;
      cyc(); start = 1'b0;
      chk("r3_overrun_clr", CW'(overrun), CW'(0));
      cycn(20);
      start = 1'b1;
      cyc(); start = 1'b0;
      chk("t4_start_ignored", cycle, CW'(21));
      cycn(15);
      chk_rec("t4_inflight", 4, CW'(32));
      is_halt = 1'b1;
      cyc(); is_halt = 1'b0;
      chk("t4_cycle", cycle, CW'(37));
      chk("t4_busy", CW'(busy), CW'(1));
      chk("t4_gap_valid", CW'(rec_valid), CW'(0));
      chk("t4_timeout", CW'(timeout), CW'(0));
      cyc();
      exp_rec = '{32'd2, 32'd37, 32'd37, 32'd37, 32'd37};
      for (int i = 0; i < 5; i++) begin
         chk_rec("t4_final", i, exp_rec[i]);
         cyc();
      end
      chk("t4_done", CW'(done), CW'(1));
      chk("t4_frozen", cycle, CW'(37));
      chk("t4_valid_off", CW'(rec_valid), CW'(0));

      // run 4: reset in the middle of a burst, then restart
      W_v = 1'b0; wv_alt = 1'b1; ev = 2'b01; start = 1'b1;
      cyc(); start = 1'b0;
      cycn(17);
      chk_rec("t6_pre", 1, CW'(16));
      rst_n = 1'b0;
      #1;
      chk("t6_valid", CW'(rec_valid), CW'(0));
      chk("t6_busy", CW'(busy), CW'(0));
      chk("t6_cycle", cycle, CW'(0));
      chk("t6_idx", CW'(rec_idx), CW'(0));
      chk("t6_data", rec_data, CW'(0));
      chk("t6_done", CW'(done), CW'(0));
      cycn(2);
      rst_n = 1'b1;
      cyc();
      start = 1'b1;
      cyc(); start = 1'b0;
      cycn(16);
      chk_rec("t6_win", 0, CW'(0));
      cyc();
      chk_rec("t6_cyc", 1, CW'(16));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
